// File: rtl/regfile_pkg.sv
// Shared defaults, index typedef and index-width helper for the multi-port register file.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_REGS_DEF   = 32;
  localparam int NUM_READ_DEF   = 2;

  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_idx_t;

  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode-stage bus of the register file: one write, one reserve and NUM_READ packed read ports.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int NUM_READ   = NUM_READ_DEF,
  parameter int IDX_W      = idx_width(NUM_REGS)
);

  logic                           RegWrite;
  logic [IDX_W-1:0]               WriteRegister;
  logic [DATA_WIDTH-1:0]          WriteData;
  logic                           Reserve;
  logic [IDX_W-1:0]               ReserveRegister;
  logic [NUM_READ*IDX_W-1:0]      ReadRegister;
  logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
  logic [NUM_READ-1:0]            ReadPending;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output Reserve, ReserveRegister, ReadRegister,
    input  ReadData, ReadPending
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  Reserve, ReserveRegister, ReadRegister,
    output ReadData, ReadPending
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, zero-register forcing and pending lookup.
// Write-to-read bypass is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ZERO_REG   = NUM_REGS - 1,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [NUM_REGS-1:0]                 pending,
  input  logic [IDX_W-1:0]                    read_idx,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                rsv_en,
  input  logic [IDX_W-1:0]                    rsv_idx,
  output logic [DATA_WIDTH-1:0]               read_data,
  output logic                                read_pending
);

  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = ^{wr_en, wr_idx, wr_data, rsv_en, rsv_idx};
`endif

  always_comb begin
    read_data    = regs[read_idx];
    read_pending = pending[read_idx];
`ifdef REGFILE_BYPASS_EN
    // A same-cycle write supersedes stored state unless a newer reservation lands on it too.
    if (wr_en && (read_idx == wr_idx)) begin
      read_data    = wr_data;
      read_pending = rsv_en && (rsv_idx == read_idx);
    end
`endif
    if (read_idx == ZERO_IDX) begin
      read_data    = '0;
      read_pending = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hard-wired zero register and pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int NUM_READ   = NUM_READ_DEF,
  parameter int ZERO_REG   = NUM_REGS - 1
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);

  localparam int               IDX_W    = idx_width(NUM_REGS);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pending_q, pending_d;
  logic                                wr_en, rsv_en;
  logic                                wr_byp, rsv_byp;

  assign wr_en  = bus.RegWrite && (bus.WriteRegister != ZERO_IDX);
  assign rsv_en = bus.Reserve && (bus.ReserveRegister != ZERO_IDX);

  // Forwarding is suppressed during reset so every output reads zero.
  assign wr_byp  = wr_en && !reset;
  assign rsv_byp = rsv_en && !reset;

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en) begin
      regs_d[bus.WriteRegister]    = bus.WriteData;
      pending_d[bus.WriteRegister] = 1'b0;
    end
    // Applied after the write clear: a same-index reserve belongs to a newer producer.
    if (rsv_en) begin
      pending_d[bus.ReserveRegister] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ZERO_REG   (ZERO_REG),
      .IDX_W      (IDX_W)
    ) u_read_port (
      .regs         (regs_q),
      .pending      (pending_q),
      .read_idx     (bus.ReadRegister[p*IDX_W +: IDX_W]),
      .wr_en        (wr_byp),
      .wr_idx       (bus.WriteRegister),
      .wr_data      (bus.WriteData),
      .rsv_en       (rsv_byp),
      .rsv_idx      (bus.ReserveRegister),
      .read_data    (bus.ReadData[p*DATA_WIDTH +: DATA_WIDTH]),
      .read_pending (bus.ReadPending[p])
    );
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the fixed 32×64 ARM register file. It provides configurable data width, register count and read-port count, with a hard-wired zero register. It adds asynchronous reset of all storage and a per-register pending scoreboard for hazard detection. Optional write-to-read bypass is selected at compile time. It sits in the decode stage of the pipelined ARM datapath, feeding operand reads and hazard logic.

## Interface
- DATA_WIDTH, 64, bits per register
- NUM_REGS, 32, register count (power of two, ≥2)
- NUM_READ, 2, number of independent read ports (≥1)
- ZERO_REG, NUM_REGS-1, index hard-wired to zero (31 = XZR)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all registers and pending bits
- RegWrite  input  1  write enable
- WriteRegister  input  $clog2(NUM_REGS)  write index
- WriteData  input  DATA_WIDTH  write value
- Reserve  input  1  mark a register as awaiting a producer
- ReserveRegister  input  $clog2(NUM_REGS)  index to reserve
- ReadRegister  input  NUM_READ × $clog2(NUM_REGS)  read indices, packed, port 0 in LSBs
- ReadData  output  NUM_READ × DATA_WIDTH  read values, packed
- ReadPending  output  NUM_READ  1 = addressed register has an outstanding reservation

## Operation
- Storage: NUM_REGS-1 real registers. ZERO_REG has no storage. It always reads 0, and writes to it are discarded.
- Write: at posedge clk, if RegWrite and WriteRegister != ZERO_REG, then regs[WriteRegister] <= WriteData.
- Read: combinational per port. ReadData[p] = regs[ReadRegister[p]], or 0 for ZERO_REG.
- Scoreboard, pending[NUM_REGS]:
  - posedge with Reserve and ReserveRegister != ZERO_REG: that pending bit set.
  - posedge with RegWrite and WriteRegister != ZERO_REG: that pending bit cleared.
  - Same index reserved and written in the same cycle: the bit ends set, because the reservation belongs to a newer producer.
  - pending[ZERO_REG] is constant 0.
- ReadPending[p] = pending[ReadRegister[p]], subject to the bypass masking in Configuration.
- Multiple ports may address the same register; each port returns the same value independently.
- Reset is asynchronous. While reset is asserted, all registers hold 0, all pending bits hold 0, and all ReadData and ReadPending outputs are 0 regardless of indices. Writes and reserves are ignored.
- Reset deasserted mid-operation: the first posedge after deassertion behaves normally, with no leftover state.

## Timing
- Write latency: data is visible on reads 1 cycle after the write posedge (0 cycles with bypass).
- Read latency: 0 cycles, combinational from ReadRegister and state.
- Reserve is visible on ReadPending in the cycle after its posedge.
- Write clears ReadPending in the cycle after its posedge (same cycle with bypass).
- No handshake or backpressure. Every cycle accepts one write and one reserve.

## Configuration
- REGFILE_BYPASS_EN defined: a port matching WriteRegister, with RegWrite=1 and the index != ZERO_REG, returns WriteData combinationally in the same cycle. Its ReadPending is forced to 0 unless Reserve targets that same index in the same cycle.
- REGFILE_BYPASS_EN undefined: a read in the cycle of a write returns the old value and the old pending bit.
- Reset overrides bypass; outputs stay 0 while reset=1.

## Structure
- Package regfile_pkg holds:
  - defaults DATA_WIDTH_DEF=64, NUM_REGS_DEF=32, NUM_READ_DEF=2
  - a typedef for the register index
  - the function computing the index width
- Sub-module regfile_read_port: one instance per read port, generated NUM_READ times. It performs index mux, zero-register forcing, optional bypass compare and pending lookup.
- Top level holds the storage array, write decode, scoreboard and reset logic.

## Test plan
- Reset, then write 0xA0 to reg 31 with RegWrite=1 → ReadData on reg 31 = 0 and ReadPending = 0, then and forever after.
- Write i×64'h0000010204080001 to regs 0–30, read back on all ports with port p addressing i and port p+1 addressing i-1 → every value matches; reg 31 reads 0.
- Reserve reg 5 → ReadPending=1 next cycle. Write reg 5 = 0x55 → ReadPending=0 next cycle and ReadData=0x55.
- Same cycle reserve reg 7 and write reg 7 = 0x77 → next cycle ReadPending=1 and ReadData=0x77.
- Write reg 3 = 0x33 while reading reg 3 in the same cycle:
  - with REGFILE_BYPASS_EN → ReadData=0x33 in that cycle
  - without → old value in that cycle, 0x33 the next cycle
- Load regs 0–4 with nonzero data and reserve reg 2, then assert reset between clock edges → all ReadData and ReadPending = 0 immediately. After deassertion, regs read 0 until rewritten.
